grid_stream_loader: RTL

//  Byte-stream receiver for the puzzle grid: accepts ASCII map text ('@' roll, '.' empty, LF row end)

---
 rtl/grid_stream_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/grid_stream_loader.sv
// Assembles a DEPTH x WIDTH bit grid from an ASCII map stream ('@', '.', LF, CR ignored).
// Optional `ROLL_COUNT_EN adds a roll_count output counting accepted '@' bytes.
module grid_stream_loader #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic [WIDTH*DEPTH-1:0]   grid_flat,
  output logic                     grid_valid,
  input  logic                     grid_ack,
  output logic                     error,
  output logic [1:0]               err_code
`ifdef ROLL_COUNT_EN
  ,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0] roll_count
`endif
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (WIDTH * DEPTH > 1) ? $clog2(WIDTH * DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CHAR  = 2'b01;
  localparam logic [1:0] ERR_SHORT = 2'b10;
  localparam logic [1:0] ERR_LONG  = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t           state, state_nx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             hs;
  logic             is_cell;
  logic             clear;
  logic             ack_clr;
  logic             cell_wr;
  logic             row_end;
  logic [1:0]       err_nx;
  logic [IDX_W-1:0] wr_idx;

  assign s_ready = (state == LOAD);
  assign hs      = s_valid & s_ready;
  assign is_cell = (s_data == CH_ROLL) || (s_data == CH_EMPTY);
  assign wr_idx  = IDX_W'(row) * IDX_W'(WIDTH) + IDX_W'(col);

  always_comb begin
    state_nx = state;
    err_nx   = ERR_NONE;
    clear    = 1'b0;
    ack_clr  = 1'b0;
    cell_wr  = 1'b0;
    row_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          clear    = 1'b1;
        end
      end
      LOAD: begin
        // start and grid_ack are deliberately ignored while a load is in flight
        if (hs) begin
          if (is_cell) begin
            if (col == COL_FULL) err_nx = ERR_LONG;
            else                 cell_wr = 1'b1;
          end else if (s_data == CH_LF) begin
            if (col != COL_FULL)      err_nx   = ERR_SHORT;
            else if (row == ROW_LAST) state_nx = DONE;
            else                      row_end  = 1'b1;
          end else if (s_data != CH_CR) begin
            err_nx = ERR_CHAR;
          end
          if (err_nx != ERR_NONE) state_nx = ERROR;
        end
      end
      DONE, ERROR: begin
        if (start) begin
          state_nx = LOAD;
          clear    = 1'b1;
        end else if (grid_ack) begin
          state_nx = IDLE;
          ack_clr  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grid_flat  <= '0;
      row        <= '0;
      col        <= '0;
      grid_valid <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nx;
      grid_valid <= (state_nx == DONE);
      if (clear) begin
        grid_flat <= '0;
        row       <= '0;
        col       <= '0;
        error     <= 1'b0;
        err_code  <= ERR_NONE;
      end else begin
        if (cell_wr) begin
          grid_flat[wr_idx] <= (s_data == CH_ROLL);
          col               <= col + 1'b1;
        end
        if (row_end) begin
          col <= '0;
          row <= row + 1'b1;
        end
        // grid_flat keeps the partial image on error for post-mortem inspection
        if (err_nx != ERR_NONE) begin
          error    <= 1'b1;
          err_code <= err_nx;
        end
        if (ack_clr) begin
          error    <= 1'b0;
          err_code <= ERR_NONE;
        end
      end
    end
  end

`ifdef ROLL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roll_count <= '0;
    end else if (clear) begin
      roll_count <= '0;
    end else if (cell_wr && (s_data == CH_ROLL)) begin
      roll_count <= roll_count + 1'b1;
    end
  end
`endif

endmodule
